// File: rtl/fighter_sprite_fetch_pkg.sv
// Shared types for the fighter sprite fetch stage: animation states,
// the transparent palette index and the screen coordinate type.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, PLAY} anim_state_t;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/fighter_sprite_fetch_anim_ctrl.sv
// Animation sequencer for the fighter sprite. Frames only advance on
// vsync_pulse, so the frame number is stable for a whole video frame.
//
//   state | meaning
//   IDLE  | no animation; frame 0 shown, waiting for trigger
//   ARMED | trigger seen; animation starts at the next vsync
//   PLAY  | stepping frames, each held for FRAME_HOLD vsyncs
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int N_FRAMES   = 4,
  parameter int FRAME_HOLD = 6,
  parameter int FRAME_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync_pulse,
  input  logic               trigger,
  output logic [FRAME_W-1:0] frame,
  output logic               busy
);

  localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  anim_state_t         state, state_nx;
  logic [FRAME_W-1:0]  frame_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_nx;

  // State, frame and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      frame    <= frame_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Next-state logic; trigger is only honoured in IDLE (no restart mid-animation).
  always_comb begin
    state_nx = state;
    frame_nx = frame;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        frame_nx = '0;
        hold_nx  = '0;
        if (trigger) state_nx = vsync_pulse ? PLAY : ARMED;
      end
      ARMED: begin
        if (vsync_pulse) begin
          state_nx = PLAY;
          frame_nx = '0;
          hold_nx  = '0;
        end
      end
      PLAY: begin
        if (vsync_pulse) begin
          if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
            hold_nx = '0;
            if (frame == FRAME_W'(N_FRAMES - 1)) begin
              state_nx = IDLE;
              frame_nx = '0;
            end else begin
              frame_nx = frame + FRAME_W'(1);
            end
          end else begin
            hold_nx = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        frame_nx = '0;
        hold_nx  = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: rtl/fighter_sprite_fetch.sv
// Per-pixel sprite fetch: bounding-box hit test, sprite ROM address
// generation (frame offset + optional mirroring) and registered palette
// index / opaque flag, three cycles after DrawX/DrawY.
// Optional feature macro: SPRITE_MIRROR_EN (horizontal mirroring via
// facing_left, latched at vsync). Undefined: facing_left is ignored.
module fighter_sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 96,
  parameter int N_FRAMES   = 4,
  parameter int FRAME_HOLD = 6,
  parameter int ADDR_W     = $clog2(SPR_W * SPR_H * N_FRAMES)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  logic              vsync_pulse,
  input  coord_t            sprite_x,
  input  coord_t            sprite_y,
  input  logic              facing_left,
  input  logic              trigger,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  output logic              pix_opaque,
  output logic              busy
);

  localparam int          COL_W   = $clog2(SPR_W);
  localparam int          ROW_W   = $clog2(SPR_H);
  localparam int          FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  logic [FRAME_W-1:0] frame;
  logic [10:0]        dx11, dy11, sx11, sy11;
  logic [COL_W-1:0]   col, col_sel;
  logic [ROW_W-1:0]   row;
  logic               hit, hit_q1, hit_q2;
  logic [ADDR_W-1:0]  addr_nx;

  sprite_anim_ctrl #(
    .N_FRAMES   (N_FRAMES),
    .FRAME_HOLD (FRAME_HOLD),
    .FRAME_W    (FRAME_W)
  ) u_anim (
    .clk         (Clk),
    .rst_n       (Reset_n),
    .vsync_pulse (vsync_pulse),
    .trigger     (trigger),
    .frame       (frame),
    .busy        (busy)
  );

`ifdef SPRITE_MIRROR_EN
  logic facing_q;

  // Facing is latched at vsync so a direction change never tears mid-screen.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         facing_q <= 1'b0;
    else if (vsync_pulse) facing_q <= facing_left;
  end

  assign col_sel = facing_q ? (COL_W'(SPR_W - 1) - col) : col;
`else
  logic unused_facing;
  assign unused_facing = facing_left;
  assign col_sel       = col;
`endif

  // Hit test at 11 bits so a sprite near the right/bottom edge cannot wrap.
  always_comb begin
    dx11 = {1'b0, DrawX};
    dy11 = {1'b0, DrawY};
    sx11 = {1'b0, sprite_x};
    sy11 = {1'b0, sprite_y};
    hit  = (dx11 >= sx11) && (dx11 < sx11 + SPR_W11) &&
           (dy11 >= sy11) && (dy11 < sy11 + SPR_H11);
    col  = COL_W'(DrawX - sprite_x);
    row  = ROW_W'(DrawY - sprite_y);
    addr_nx = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H) +
              ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_sel);
  end

  // Address stage, hit delay line and palette output stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr   <= '0;
      hit_q1     <= 1'b0;
      hit_q2     <= 1'b0;
      pal_index  <= TRANSPARENT_IDX;
      pix_opaque <= 1'b0;
    end else begin
      if (hit) rom_addr <= addr_nx;
      hit_q1     <= hit;
      hit_q2     <= hit_q1;
      pal_index  <= hit_q2 ? rom_data : TRANSPARENT_IDX;
      pix_opaque <= hit_q2 && (rom_data != TRANSPARENT_IDX);
    end
  end

endmodule

// File: tb/tb_fighter_sprite_fetch.sv
// Self-checking bench for fighter_sprite_fetch with a behavioural model
// of the hit test, address, ROM pipeline and animation timeline.
module tb_fighter_sprite_fetch;

  localparam int SPR_W      = 64;
  localparam int SPR_H      = 96;
  localparam int N_FRAMES   = 4;
  localparam int FRAME_HOLD = 6;
  localparam int ADDR_W     = 15;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [9:0]        DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic              vsync_pulse = 1'b0, facing_left = 1'b0, trigger = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        pal_index;
  logic              pix_opaque, busy;

  always #5 Clk = ~Clk;

  fighter_sprite_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .N_FRAMES(N_FRAMES), .FRAME_HOLD(FRAME_HOLD)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .vsync_pulse(vsync_pulse), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .facing_left(facing_left), .trigger(trigger), .rom_addr(rom_addr),
    .rom_data(rom_data), .pal_index(pal_index), .pix_opaque(pix_opaque),
    .busy(busy)
  );

  // Synchronous sprite ROM: data one cycle after the address.
  logic [3:0] rom_mem [0:32767];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  int n_checks = 0;
  int n_errors = 0;

  // Model: 0 idle, 1 armed, 2 playing; m_cnt = vsyncs seen since PLAY entry.
  int m_state = 0, m_cnt = 0, m_facing = 0, m_last_addr = 0;
  int spr_x = 0, spr_y = 0;
  int qx[$], qy[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_frame();
    return (m_state == 2) ? m_cnt / FRAME_HOLD : 0;
  endfunction

  function automatic int mirror_on();
`ifdef SPRITE_MIRROR_EN
    return m_facing;
`else
    return 0;
`endif
  endfunction

  task automatic park();
    DrawX = spr_x[9:0];
    DrawY = (spr_y >= 1) ? 10'(spr_y - 1) : 10'(spr_y + SPR_H);
  endtask

  task automatic set_sprite(input int x, input int y);
    spr_x = x; spr_y = y;
    sprite_x = x[9:0]; sprite_y = y[9:0];
    park();
  endtask

  task automatic add_rand(input int n);
    for (int i = 0; i < n; i++) begin
      qx.push_back((spr_x + int'($urandom_range(0, SPR_W + 7)) - 4) & 1023);
      qy.push_back((spr_y + int'($urandom_range(0, SPR_H + 7)) - 4) & 1023);
    end
  endtask

  // Streams the queued pixels one per clock and checks every pipeline output.
  task automatic run_burst();
    int n = qx.size();
    int ea[$], ep[$], eo[$];
    for (int k = 0; k < n + 3; k++) begin
      @(negedge Clk);
      if (k >= 1 && k <= n) check_val("rom_addr", rom_addr, ea[k-1]);
      if (k >= 3) begin
        check_val("pal_index", pal_index, ep[k-3]);
        check_val("pix_opaque", pix_opaque, eo[k-3]);
      end
      if (k < n) begin
        int col = qx[k] - spr_x;
        int row = qy[k] - spr_y;
        bit h = (col >= 0) && (col < SPR_W) && (row >= 0) && (row < SPR_H);
        int a = 0;
        if (h) begin
          int c = mirror_on() ? (SPR_W - 1 - col) : col;
          a = m_frame() * SPR_W * SPR_H + row * SPR_W + c;
          m_last_addr = a;
        end
        ea.push_back(m_last_addr);
        ep.push_back(h ? int'(rom_mem[a]) : 0);
        eo.push_back((h && rom_mem[a] != 4'd0) ? 1 : 0);
        DrawX = qx[k][9:0];
        DrawY = qy[k][9:0];
      end else begin
        park();
      end
    end
    qx.delete();
    qy.delete();
  endtask

  task automatic one_pixel(input int x, input int y);
    qx.push_back(x); qy.push_back(y);
    run_burst();
  endtask

  task automatic vsync(input bit trig);
    @(negedge Clk);
    vsync_pulse = 1'b1;
    trigger = trig;
    @(negedge Clk);
    vsync_pulse = 1'b0;
    trigger = 1'b0;
    m_facing = facing_left;
    case (m_state)
      0: if (trig) begin m_state = 2; m_cnt = 0; end
      1: begin m_state = 2; m_cnt = 0; end
      default: begin
        m_cnt++;
        if (m_cnt == FRAME_HOLD * N_FRAMES) begin m_state = 0; m_cnt = 0; end
      end
    endcase
    check_val("busy_vsync", busy, (m_state != 0));
  endtask

  task automatic trig_pulse();
    @(negedge Clk);
    trigger = 1'b1;
    @(negedge Clk);
    trigger = 1'b0;
    if (m_state == 0) m_state = 1;
    check_val("busy_trig", busy, (m_state != 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32768; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[330]   = 4'd7;
    rom_mem[331]   = 4'd0;
    rom_mem[373]   = 4'd9;
    rom_mem[6474]  = 4'd3;
    rom_mem[12618] = 4'd5;

    // Reset state
    repeat (3) @(negedge Clk);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_pal", pal_index, 0);
    check_val("rst_opaque", pix_opaque, 0);
    check_val("rst_busy", busy, 0);
    set_sprite(100, 200);
    Reset_n = 1'b1;

    // Address, bounds and transparency, facing right
    qx = '{164, 99, 111, 163, 100, 110, 164, 110};
    qy = '{205, 205, 205, 295, 200, 296, 205, 205};
    run_burst();
    check_val("plan_addr330", rom_addr, 330);
    add_rand(24);
    run_burst();

    // Mirroring latched at vsync
    facing_left = 1'b1;
    vsync(1'b0);
    facing_left = 1'b0;
    one_pixel(110, 205);
`ifdef SPRITE_MIRROR_EN
    check_val("plan_mirror", rom_addr, 373);
`else
    check_val("plan_mirror", rom_addr, 330);
`endif
    add_rand(12);
    run_burst();
    vsync(1'b0);

    // Sprite near the far edge: no wrap of the bounding box
    set_sprite(1000, 1000);
    qx = '{5, 1010, 1010, 1023, 999, 1010};
    qy = '{1005, 1005, 1023, 1000, 1005, 5};
    run_burst();
    add_rand(16);
    run_burst();

    // Animation: trigger, ARMED until first vsync, 24 PLAY vsyncs
    set_sprite(100, 200);
    trig_pulse();
    trig_pulse();
    for (int v = 1; v <= 26; v++) begin
      vsync(1'b0);
      one_pixel(110, 205);
      if (v == 7)  check_val("plan_frame1", rom_addr, 6474);
      if (v == 13) check_val("plan_frame2", rom_addr, 12618);
      if (v == 24) check_val("plan_busy_last", busy, 1);
      if (v == 25) check_val("plan_done", busy, 0);
      if (v == 10) trig_pulse();
    end

    // Trigger coincident with vsync, further triggers ignored
    vsync(1'b1);
    for (int v = 1; v <= 24; v++) begin
      if (v == 5) trig_pulse();
      vsync((v == 3 || v == 10) ? 1'b1 : 1'b0);
      if (v == 12) begin
        one_pixel(110, 205);
        check_val("sim_frame2", rom_addr, 12618);
      end
      if (v == 23) check_val("sim_busy_last", busy, 1);
      if (v == 24) check_val("sim_done", busy, 0);
    end

    // Reset mid-animation during frame 2
    vsync(1'b1);
    for (int v = 0; v < 13; v++) vsync(1'b0);
    @(negedge Clk);
    DrawX = 10'd110; DrawY = 10'd205;
    m_last_addr = 12618;
    repeat (4) @(negedge Clk);
    check_val("pre_rst_pal", pal_index, 5);
    check_val("pre_rst_addr", rom_addr, 12618);
    #2 Reset_n = 1'b0;
    #1;
    check_val("async_busy", busy, 0);
    check_val("async_pal", pal_index, 0);
    check_val("async_opaque", pix_opaque, 0);
    check_val("async_addr", rom_addr, 0);
    m_state = 0; m_cnt = 0; m_facing = 0; m_last_addr = 0;
    @(negedge Clk);
    park();
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_val("post_rst_busy", busy, 0);
    one_pixel(110, 205);
    check_val("post_rst_frame0", rom_addr, 330);
    vsync(1'b0);

    // Randomised mix of events
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          facing_left = 1'($urandom_range(0, 1));
          vsync(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end
        1: trig_pulse();
        2: begin add_rand(6); run_burst(); end
        3: begin
          facing_left = 1'($urandom_range(0, 1));
          add_rand(3);
          run_burst();
        end
        default: begin
          set_sprite($urandom_range(0, 1023), $urandom_range(0, 1023));
          add_rand(6);
          run_burst();
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
